// File: rtl/led_matrix_serializer.sv
// -----------------------------------------------------------------------------
// led_matrix_serializer
//
// Serialises an 8x8 LED matrix frame into an external shift-register chain.
// Each row is fetched from the board (row_sel -> row_data), shifted out MSB
// first using a divided serial clock, latched with ser_latch, and then driven
// onto the one-hot row_en lines. Eight rows make one frame, ending with a
// one-cycle done pulse.
//
// Parameters
//   CLK_DIV    clk cycles per ser_clk half-period (1..255)
//
// Ports
//   clk        system clock, rising-edge active
//   reset      asynchronous, active-low reset
//   start      frame request, honoured only while idle
//   row_data   contents of the row currently addressed by row_sel
//   row_sel    registered row address being fetched (0..7)
//   ser_data   serial data to the LED shift-register chain
//   ser_clk    serial shift clock (chain samples on its rising edge)
//   ser_latch  storage latch strobe to the chain
//   row_en     one-hot row drive, blanked to 8'h00 while latching
//   busy       high from FETCH of row 0 until the frame completes
//   done       one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module led_matrix_serializer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] row_data,
  output logic [2:0] row_sel,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch,
  output logic [7:0] row_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    DONE
  } state_t;

  // Reload value for the half-period counter; the counter runs down to zero,
  // so each timed state lasts exactly CLK_DIV cycles.
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] shifter;
  logic [2:0] bit_cnt;
  logic [7:0] div_cnt;

  // NOTE: all state and outputs live in one clocked block and use
  // non-blocking assignments, so every output is a flop and each branch
  // sees the pre-edge values of the registers it reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shifter   <= 8'h00;
      bit_cnt   <= 3'd0;
      div_cnt   <= 8'h00;
      row_sel   <= 3'd0;
      ser_data  <= 1'b0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      row_en    <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= FETCH;
            row_sel <= 3'd0;
            busy    <= 1'b1;
          end
        end

        // One-cycle fetch: row_data is captured here and nowhere else, so
        // later changes on row_data cannot disturb the row in flight.
        FETCH: begin
          shifter  <= row_data;
          ser_data <= row_data[7];
          bit_cnt  <= 3'd0;
          ser_clk  <= 1'b0;
          div_cnt  <= DIV_M1;
          state    <= SHIFT_LO;
        end

        SHIFT_LO: begin
          if (div_cnt == 8'h00) begin
            ser_clk <= 1'b1;
            div_cnt <= DIV_M1;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - 8'h01;
          end
        end

        // ser_data only changes on the SHIFT_HI -> SHIFT_LO edge, so it is
        // stable across both halves of every bit.
        SHIFT_HI: begin
          if (div_cnt == 8'h00) begin
            ser_clk <= 1'b0;
            div_cnt <= DIV_M1;
            if (bit_cnt == 3'd7) begin
              ser_latch <= 1'b1;
              row_en    <= 8'h00;
              state     <= LATCH;
            end else begin
              shifter  <= {shifter[6:0], 1'b0};
              ser_data <= shifter[6];
              bit_cnt  <= bit_cnt + 3'd1;
              state    <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt - 8'h01;
          end
        end

        // Rows are blanked while the chain latches, then the freshly latched
        // row is enabled.
        LATCH: begin
          if (div_cnt == 8'h00) begin
            ser_latch <= 1'b0;
            row_en    <= 8'h01 << row_sel;
            if (row_sel == 3'd7) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row_sel <= row_sel + 3'd1;
              state   <= FETCH;
            end
          end else begin
            div_cnt <= div_cnt - 8'h01;
          end
        end

        // start is deliberately ignored here; it is only seen again in IDLE.
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_serializer.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_serializer
//
// Two instances (CLK_DIV=4 and CLK_DIV=1) share clk and reset. A negedge
// monitor watches the selected instance: it assembles the byte clocked out on
// ser_clk rising edges, compares it at each ser_latch pulse with the byte the
// board held when that row was fetched, and measures pulse widths, latch
// counts, done pulses and frame length against the arithmetic of the spec.
// -----------------------------------------------------------------------------
module tb_led_matrix_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_a, start_b;
  logic [7:0] pat [8];
  logic [7:0] new_pat [8];

  logic [2:0] row_sel_a, row_sel_b;
  logic [7:0] row_data_a, row_data_b;
  logic       ser_data_a, ser_data_b, ser_clk_a, ser_clk_b;
  logic       ser_latch_a, ser_latch_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] row_en_a, row_en_b;

  assign row_data_a = pat[row_sel_a];
  assign row_data_b = pat[row_sel_b];

  led_matrix_serializer #(.CLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .row_data(row_data_a),
    .row_sel(row_sel_a), .ser_data(ser_data_a), .ser_clk(ser_clk_a),
    .ser_latch(ser_latch_a), .row_en(row_en_a), .busy(busy_a), .done(done_a)
  );

  led_matrix_serializer #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .row_data(row_data_b),
    .row_sel(row_sel_b), .ser_data(ser_data_b), .ser_clk(ser_clk_b),
    .ser_latch(ser_latch_b), .row_en(row_en_b), .busy(busy_b), .done(done_b)
  );

  // Observed instance
  logic       sel;
  int         div;
  logic [2:0] o_row_sel;
  logic       o_sdata, o_sclk, o_latch, o_busy, o_done;
  logic [7:0] o_row_en;

  always_comb begin
    o_row_sel = sel ? row_sel_b   : row_sel_a;
    o_sdata   = sel ? ser_data_b  : ser_data_a;
    o_sclk    = sel ? ser_clk_b   : ser_clk_a;
    o_latch   = sel ? ser_latch_b : ser_latch_a;
    o_row_en  = sel ? row_en_b    : row_en_a;
    o_busy    = sel ? busy_b      : busy_a;
    o_done    = sel ? done_b      : done_a;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic       mon_on = 1'b0;
  logic [7:0] exp_row [8];
  logic [7:0] bits;
  logic       cur_bit;
  int nbits, latch_cnt, done_cnt, busy_cyc, busy_falls, hi_run, lat_run, hi_err;
  logic p_sclk = 1'b0, p_latch = 1'b0, p_busy = 1'b0;

  task automatic clear_stats();
    bits = 8'h00; nbits = 0; latch_cnt = 0; done_cnt = 0; busy_cyc = 0;
    busy_falls = 0; hi_run = 0; lat_run = 0; hi_err = 0; cur_bit = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [2:0] idx;
    if (mon_on) begin
      if (o_busy) busy_cyc++;
      if (!o_busy && p_busy) busy_falls++;
      if (o_done) done_cnt++;
      if (o_sclk) begin
        hi_run++;
        if (!p_sclk) begin
          bits    = {bits[6:0], o_sdata};
          cur_bit = o_sdata;
          nbits++;
        end else if (o_sdata !== cur_bit) begin
          hi_err++;
        end
      end else if (p_sclk) begin
        if (hi_run != div) hi_err++;
        hi_run = 0;
      end
      if (o_latch) begin
        lat_run++;
        if (!p_latch) begin
          idx = latch_cnt[2:0];
          check("row_bits", 32'(bits), 32'(exp_row[idx]));
          check("bit_count", nbits, 8);
          check("blank_row_en", 32'(o_row_en), 32'h0);
          check("latch_sclk_low", 32'(o_sclk), 32'h0);
          nbits = 0;
          latch_cnt++;
        end
      end else if (p_latch) begin
        idx = 3'(latch_cnt - 1);
        check("latch_len", lat_run, div);
        check("row_en", 32'(o_row_en), 32'(8'h01 << idx));
        lat_run = 0;
      end
    end
    p_sclk  = o_sclk;
    p_latch = o_latch;
    p_busy  = o_busy;
  end

  // ---------------------------------------------------------------------------
  // Frame runner
  //   mode 0: plain frame
  //   mode 1: extra start pulse during row 3 shifting (must be ignored)
  //   mode 2: board contents switch to new_pat during row 2 shifting
  //   mode 3: reset asserted during SHIFT_HI of row 5
  //   mode 4: start held high through DONE (relaunches on first IDLE cycle)
  // ---------------------------------------------------------------------------
  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic run_frame(input logic s, input int mode);
    int   cyc, limit, frame_len;
    logic aborted, changed, pulsed;
    sel = s;
    div = s ? 1 : 4;
    frame_len = 8 * (17 * div + 1);
    limit = frame_len + 20;
    for (int i = 0; i < 8; i++) exp_row[i] = pat[i];
    clear_stats();
    @(negedge clk);
    mon_on = 1'b1;
    set_start(1'b1);
    @(negedge clk);
    if (mode != 4) set_start(1'b0);
    cyc = 0; aborted = 1'b0; changed = 1'b0; pulsed = 1'b0;
    while (done_cnt == 0 && !aborted && cyc < limit) begin
      @(negedge clk);
      #1;
      cyc++;
      case (mode)
        1: begin
          if (!pulsed && o_row_sel == 3'd3 && o_sclk) begin
            set_start(1'b1);
            pulsed = 1'b1;
          end else begin
            set_start(1'b0);
          end
        end
        2: begin
          if (!changed && o_row_sel == 3'd2 && o_sclk) begin
            for (int i = 0; i < 8; i++) pat[i] = new_pat[i];
            for (int i = 3; i < 8; i++) exp_row[i] = new_pat[i];
            changed = 1'b1;
          end
        end
        3: begin
          if (o_row_sel == 3'd5 && o_sclk) begin
            mon_on = 1'b0;
            reset  = 1'b0;
            #1;
            check("reset_outs", 32'({o_row_sel, o_sdata, o_sclk, o_latch, o_row_en, o_busy, o_done}), 32'h0);
            aborted = 1'b1;
          end
        end
        default: ;
      endcase
    end
    check("frame_finished", 32'(done_cnt > 0 || aborted), 32'h1);

    if (aborted) begin
      check("abort_latches", latch_cnt, 5);
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(o_done), 32'h0);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("after_release_idle", 32'({o_busy, o_latch, o_done, o_row_en}), 32'h0);
    end else if (mode == 4) begin
      // This negedge shows DONE; next is IDLE (busy 0), then FETCH (busy 1).
      check("held_done_busy", 32'(o_busy), 32'h0);
      @(negedge clk); #1;
      check("held_idle", 32'(o_busy), 32'h0);
      @(negedge clk); #1;
      check("held_relaunch", 32'(o_busy), 32'h1);
      set_start(1'b0);
      mon_on = 1'b0;
      cyc = 0;
      while (!o_done && cyc < limit) begin
        @(negedge clk); #1;
        cyc++;
      end
      check("held_second_done", 32'(o_done), 32'h1);
    end else begin
      repeat (3) @(negedge clk);
      #1;
      check("latch_count", latch_cnt, 8);
      check("done_count", done_cnt, 1);
      check("frame_len", busy_cyc, frame_len);
      check("busy_falls", busy_falls, 1);
      check("sclk_hi_errs", hi_err, 0);
      check("final_row_en", 32'(o_row_en), 32'h80);
      check("final_busy", 32'(o_busy), 32'h0);
    end
    mon_on = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
    sel = 1'b0; div = 4;
    for (int i = 0; i < 8; i++) begin
      pat[i] = 8'h00;
      new_pat[i] = 8'h00;
    end
    clear_stats();
    repeat (2) @(negedge clk);
    check("rst_a", 32'({row_sel_a, ser_data_a, ser_clk_a, ser_latch_a, row_en_a, busy_a, done_a}), 32'h0);
    check("rst_b", 32'({row_sel_b, ser_data_b, ser_clk_b, ser_latch_b, row_en_b, busy_b, done_b}), 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_start", 32'({busy_a, busy_b}), 32'h0);

    // A5 on every row
    for (int i = 0; i < 8; i++) pat[i] = 8'hA5;
    run_frame(1'b0, 0);

    // Walking one: row r holds 1<<r
    for (int i = 0; i < 8; i++) pat[i] = 8'h01 << i;
    run_frame(1'b0, 0);

    // Extra start mid-frame is ignored
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    run_frame(1'b0, 1);

    // Reset mid-frame, then a full frame after release
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    run_frame(1'b0, 3);
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    run_frame(1'b0, 0);

    // CLK_DIV=1 with all ones, then random
    for (int i = 0; i < 8; i++) pat[i] = 8'hFF;
    run_frame(1'b1, 0);
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    run_frame(1'b1, 0);

    // Board changes from 00 to FF while row 2 is shifting
    for (int i = 0; i < 8; i++) begin
      pat[i] = 8'h00;
      new_pat[i] = 8'hFF;
    end
    run_frame(1'b0, 2);
    for (int i = 0; i < 8; i++) begin
      pat[i] = 8'($urandom);
      new_pat[i] = 8'($urandom);
    end
    run_frame(1'b1, 2);

    // start held high across the end of a frame
    for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
    run_frame(1'b0, 4);

    // Random frames on either instance
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
      run_frame(1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_matrix_serializer.md
LED_MATRIX_SERIALIZER -- requirements
Module: led_matrix_serializer

Interface
REQ-001 The block SHALL have one parameter: CLK_DIV, default 4, number of clk cycles per ser_clk half-period (legal range 1..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed in REQ-003 to REQ-012.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 row_data  input  8  board row contents (one 8-bit row of the board shift registers) for the row addressed by row_sel; bit 7 sent first.
REQ-007 row_sel  output  3  registered row address being fetched (0..7).
REQ-008 ser_data  output  1  serial data to the external LED shift-register chain.
REQ-009 ser_clk  output  1  serial shift clock; the external chain samples ser_data on its rising edge.
REQ-010 ser_latch  output  1  storage latch strobe to the external chain.
REQ-011 row_en  output  8  one-hot row drive for the LED matrix.
REQ-012 busy  output  1  high from the cycle after start is accepted until done; done  output  1  one-cycle frame-complete pulse.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH and DONE, and all outputs SHALL be registered.
REQ-014 IDLE: when start=1, the next state SHALL be FETCH with row counter r=0, row_sel=0 and busy=1; when start=0, the FSM SHALL stay in IDLE.
REQ-015 FETCH: the FSM SHALL last one cycle and SHALL load row_data into an 8-bit internal shifter at its closing edge, with ser_data=row_data[7], bit count=0, and next state SHIFT_LO.
REQ-016 SHIFT_LO: ser_clk SHALL be 0 for exactly CLK_DIV cycles, after which the next state SHALL be SHIFT_HI.
REQ-017 SHIFT_HI: ser_clk SHALL be 1 for exactly CLK_DIV cycles, and ser_data SHALL be stable throughout SHIFT_LO and SHIFT_HI of the same bit.
REQ-018 At the end of SHIFT_HI with bit count<7, the shifter SHALL shift left, ser_data SHALL take the next bit, the bit count SHALL increment and the next state SHALL be SHIFT_LO; with bit count=7, the next state SHALL be LATCH.
REQ-019 On entering LATCH, ser_latch SHALL be 1, ser_clk SHALL be 0 and row_en SHALL be 8'h00 (blanking), for exactly CLK_DIV cycles.
REQ-020 At the end of LATCH, ser_latch SHALL go to 0 and row_en SHALL become 1<<r; if r<7, r and row_sel SHALL increment and the next state SHALL be FETCH; if r=7, the next state SHALL be DONE.
REQ-021 DONE: done=1 and busy=0 for one cycle, then the FSM SHALL enter IDLE, and row_en SHALL hold 8'h80 until the next frame's first LATCH.
REQ-022 Timing: each row SHALL take 17*CLK_DIV+1 cycles and each frame 8*(17*CLK_DIV+1) cycles from FETCH entry to DONE entry; with CLK_DIV=4 this is 69 cycles per row and 552 cycles per frame.
REQ-023 A start asserted while busy=1 or in DONE SHALL be ignored and not queued; start held high continuously SHALL launch a new frame on the first IDLE cycle.
REQ-024 The ser_clk half-period counter SHALL be 8 bits wide, SHALL reload to CLK_DIV-1 on each state entry and SHALL not wrap.
REQ-025 row_data SHALL be sampled only at the FETCH edge, so changes in row_data during shifting SHALL not affect the row in flight.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force state=IDLE, r=0, row_sel=0, ser_data=0, ser_clk=0, ser_latch=0, row_en=8'h00, busy=0, done=0 and clear the shifter and counters.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no latch pulse and no done pulse, and after release the block SHALL wait in IDLE for start.
REQ-028 Reset release SHALL take effect on the next rising clk edge, and start SHALL be honoured no earlier than the first edge after release.

Verification
REQ-029 CLK_DIV=4, row_data=8'hA5 for all rows, single start pulse -> each row shifts 1,0,1,0,0,1,0,1 on ser_clk rising edges; 8 ser_latch pulses of 4 cycles each; done at cycle 552 after FETCH entry.
REQ-030 row_data=8'h01<<row_sel -> latched patterns 01,02,...,80, and row_en sequence 01,02,...,80 with 8'h00 during each LATCH.
REQ-031 start pulsed again at row 3 mid-shift -> ignored: exactly 8 latches and 1 done pulse, busy continuous.
REQ-032 reset=0 asserted during SHIFT_HI of row 5 -> all outputs 0 within the same cycle; no done pulse; a new start after release runs a full 552-cycle frame.
REQ-033 CLK_DIV=1, row_data=8'hFF -> ser_clk toggles every cycle; row takes 18 cycles; frame takes 144 cycles.
REQ-034 row_data changed from 8'h00 to 8'hFF during row 2 shifting -> row 2 still sends 8'h00, and row 3 sends 8'hFF.
